// File: rtl/ram_block_ci_pkg.sv
// Shared constants for the RAM custom-instruction block: opcodes, FSM
// state encoding, and the result returned for unknown opcodes.
package ram_block_ci_pkg;

    localparam int DATA_WIDTH = 32;

    // Opcodes carried in valueA[31:29]
    localparam logic [2:0] OP_READ    = 3'b000;
    localparam logic [2:0] OP_WRITE   = 3'b001;
    localparam logic [2:0] OP_SET_LEN = 3'b010;
    localparam logic [2:0] OP_FILL    = 3'b011;
    localparam logic [2:0] OP_COPY    = 3'b100;

    // Controller states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_READ   = 3'd1;
    localparam logic [2:0] ST_FILL   = 3'd2;
    localparam logic [2:0] ST_COPY   = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    localparam logic [DATA_WIDTH-1:0] ILLEGAL_RESULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/ram_block_dpram.sv
// Simple dual-port RAM: one write port and one synchronous read port.
// A read of the address being written in the same cycle returns the new data.
// Contents are deliberately not reset.
module ram_block_dpram
    import ram_block_ci_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: store the word on the rising edge
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered output, write-first on address collision
    always_ff @(posedge clock) begin
        if (rd_en) begin
            if (wr_en && (wr_addr == rd_addr)) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/ram_block_ci.sv
// RAM custom-instruction block: single-word read/write plus multi-cycle
// FILL and COPY over a programmable length, backed by ram_block_dpram.
module ram_block_ci
    import ram_block_ci_pkg::*;
#(
    parameter logic [7:0] customId   = 8'd14,
    parameter int         ADDR_WIDTH = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic                  req_valid;
    logic [2:0]            opcode;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH:0]   req_len;
    logic                  unused_bits;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [31:0]           fill_data_q, fill_data_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  done_q, done_d;

    logic                  imm_done;
    logic [31:0]           imm_result;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [31:0]           rd_data;

    assign req_valid   = start && (ciN == customId);
    assign opcode      = valueA[31:29];
    assign req_addr    = valueA[ADDR_WIDTH-1:0];
    assign req_len     = (valueB[ADDR_WIDTH:0] > DEPTH_W) ? DEPTH_W : valueB[ADDR_WIDTH:0];
    assign unused_bits = ^{valueA[28:ADDR_WIDTH], valueB[31:ADDR_WIDTH+1]};

    ram_block_dpram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_dpram (
        .clock  (clock),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    // Controller: request decode in IDLE, word sequencing for FILL and COPY
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        rd_cnt_d    = rd_cnt_q;
        src_d       = src_q;
        dst_d       = dst_q;
        fill_data_d = fill_data_q;
        rd_pend_d   = 1'b0;
        done_d      = 1'b0;
        imm_done    = 1'b0;
        imm_result  = 32'd0;
        wr_en       = 1'b0;
        wr_addr     = req_addr;
        wr_data     = valueB;
        rd_en       = 1'b0;
        rd_addr     = req_addr;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    case (opcode)
                        OP_READ: begin
                            rd_en   = 1'b1;
                            state_d = ST_READ;
                            done_d  = 1'b1;
                        end
                        OP_WRITE: begin
                            wr_en    = 1'b1;
                            imm_done = 1'b1;
                        end
                        OP_SET_LEN: begin
                            len_d    = req_len;
                            imm_done = 1'b1;
                        end
                        OP_FILL, OP_COPY: begin
                            src_d       = req_addr;
                            dst_d       = valueB[ADDR_WIDTH-1:0];
                            fill_data_d = valueB;
                            cnt_d       = '0;
                            rd_cnt_d    = '0;
                            if (len_q == '0) begin
                                state_d = ST_FINISH;
                                done_d  = 1'b1;
                            end else begin
                                state_d = (opcode == OP_FILL) ? ST_FILL : ST_COPY;
                            end
                        end
                        default: begin
                            imm_done   = 1'b1;
                            imm_result = ILLEGAL_RESULT;
                        end
                    endcase
                end
            end
            ST_READ: begin
                state_d = ST_IDLE;
            end
            ST_FILL: begin
                wr_en   = 1'b1;
                wr_addr = src_q + cnt_q[ADDR_WIDTH-1:0];
                wr_data = fill_data_q;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_d == len_q) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                end
            end
            ST_COPY: begin
                if (rd_cnt_q != len_q) begin
                    rd_en     = 1'b1;
                    rd_addr   = src_q + rd_cnt_q[ADDR_WIDTH-1:0];
                    rd_cnt_d  = rd_cnt_q + CNT_ONE;
                    rd_pend_d = 1'b1;
                end
                if (rd_pend_q) begin
                    wr_en   = 1'b1;
                    wr_addr = dst_q + cnt_q[ADDR_WIDTH-1:0];
                    wr_data = rd_data;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (cnt_d == len_q) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers, cleared immediately by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            rd_cnt_q    <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            fill_data_q <= '0;
            rd_pend_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            fill_data_q <= fill_data_d;
            rd_pend_q   <= rd_pend_d;
            done_q      <= done_d;
        end
    end

    // Output mux: immediate ops answer in the request cycle, others from registered done
    always_comb begin
        done   = done_q | imm_done;
        result = 32'd0;
        if (imm_done) begin
            result = imm_result;
        end else if (done_q) begin
            if (state_q == ST_READ) begin
                result = rd_data;
            end else begin
                result = {{(31 - ADDR_WIDTH){1'b0}}, len_q};
            end
        end
    end

endmodule
